// File: rtl/ecl_ram_ctl.sv
// Initiator-side sequencer for a word-wide bank of 128x1 ECL RAM chips.
// Turns a req/ack handshake into setup, write-pulse, hold and read-access timing, with optional zero fill.
module ecl_ram_ctl #(
  parameter int unsigned WIDTH          = 36,
  parameter int unsigned WP_CYCLES      = 2,
  parameter int unsigned RD_CYCLES      = 2,
  parameter bit          CLEAR_ON_RESET = 1'b1,
  localparam int unsigned AW            = 7
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req,
  input  logic             we,
  input  logic [AW-1:0]    addr,
  input  logic [WIDTH-1:0] wdata,
  output logic             busy,
  output logic             ack,
  output logic [WIDTH-1:0] rdata,
  output logic             clear_done,
  output logic [AW-1:0]    ram_a,
  output logic [WIDTH-1:0] ram_d,
  output logic             ram_nen,
  output logic             ram_nwrite,
  input  logic [WIDTH-1:0] ram_q
);

  localparam int unsigned CMAX = (WP_CYCLES > RD_CYCLES) ? WP_CYCLES : RD_CYCLES;
  localparam int unsigned CW   = (CMAX > 1) ? $clog2(CMAX) : 1;

  localparam logic [CW-1:0] WP_LAST   = CW'(WP_CYCLES - 1);
  localparam logic [CW-1:0] RD_LAST   = CW'(RD_CYCLES - 1);
  localparam logic [AW-1:0] ADDR_LAST = '1;

  typedef enum logic [3:0] {
    CLEAR_SETUP,
    CLEAR_PULSE,
    CLEAR_HOLD,
    IDLE,
    SETUP,
    W_PULSE,
    W_HOLD,
    R_ACCESS,
    R_END
  } state_t;

  state_t            state, state_nx;
  logic [CW-1:0]     cnt, cnt_nx;
  logic              we_q, we_nx;
  logic [AW-1:0]     a_nx;
  logic [WIDTH-1:0]  d_nx;
  logic [WIDTH-1:0]  rdata_nx;
  logic              done_nx;
  logic              busy_nx;
  logic              ack_nx;
  logic              nen_nx;
  logic              nwrite_nx;

  // State and all output registers; outputs are loaded with the values of the state being entered.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= CLEAR_ON_RESET ? CLEAR_SETUP : IDLE;
      cnt        <= '0;
      we_q       <= 1'b0;
      ram_a      <= '0;
      ram_d      <= '0;
      rdata      <= '0;
      clear_done <= !CLEAR_ON_RESET;
      busy       <= CLEAR_ON_RESET;
      ack        <= 1'b0;
      ram_nen    <= 1'b1;
      ram_nwrite <= 1'b1;
    end else begin
      state      <= state_nx;
      cnt        <= cnt_nx;
      we_q       <= we_nx;
      ram_a      <= a_nx;
      ram_d      <= d_nx;
      rdata      <= rdata_nx;
      clear_done <= done_nx;
      busy       <= busy_nx;
      ack        <= ack_nx;
      ram_nen    <= nen_nx;
      ram_nwrite <= nwrite_nx;
    end
  end

  // Next-state sequencing plus the strobe pattern that belongs to the next state.
  always_comb begin
    state_nx  = state;
    cnt_nx    = cnt;
    we_nx     = we_q;
    a_nx      = ram_a;
    d_nx      = ram_d;
    rdata_nx  = rdata;
    done_nx   = clear_done;
    busy_nx   = 1'b1;
    ack_nx    = 1'b0;
    nen_nx    = 1'b1;
    nwrite_nx = 1'b1;

    unique case (state)
      CLEAR_SETUP: begin
        cnt_nx   = '0;
        state_nx = CLEAR_PULSE;
      end
      CLEAR_PULSE: begin
        if (cnt == WP_LAST) begin
          state_nx = CLEAR_HOLD;
        end else begin
          cnt_nx = cnt + CW'(1);
        end
      end
      CLEAR_HOLD: begin
        if (ram_a == ADDR_LAST) begin
          state_nx = IDLE;
          done_nx  = 1'b1;
        end else begin
          a_nx     = ram_a + AW'(1);
          d_nx     = '0;
          state_nx = CLEAR_SETUP;
        end
      end
      IDLE: begin
        if (req) begin
          a_nx     = addr;
          d_nx     = wdata;
          we_nx    = we;
          state_nx = SETUP;
        end
      end
      SETUP: begin
        cnt_nx   = '0;
        state_nx = we_q ? W_PULSE : R_ACCESS;
      end
      W_PULSE: begin
        if (cnt == WP_LAST) begin
          state_nx = W_HOLD;
        end else begin
          cnt_nx = cnt + CW'(1);
        end
      end
      W_HOLD: begin
        state_nx = IDLE;
      end
      R_ACCESS: begin
        if (cnt == RD_LAST) begin
          rdata_nx = ram_q;
          state_nx = R_END;
        end else begin
          cnt_nx = cnt + CW'(1);
        end
      end
      R_END: begin
        state_nx = IDLE;
      end
      default: begin
        state_nx = IDLE;
      end
    endcase

    unique case (state_nx)
      CLEAR_PULSE, W_PULSE: begin
        nen_nx    = 1'b0;
        nwrite_nx = 1'b0;
      end
      R_ACCESS: begin
        nen_nx = 1'b0;
      end
      W_HOLD, R_END: begin
        ack_nx = 1'b1;
      end
      IDLE: begin
        busy_nx = 1'b0;
      end
      default: begin
        busy_nx = 1'b1;
      end
    endcase
  end

endmodule

// File: tb/tb_ecl_ram_ctl.sv
// Bench for ecl_ram_ctl: behavioural RAM, cycle-level reference model checked every cycle,
// and directed accesses with hand-computed timing and data.
module tb_ecl_ram_ctl;

  localparam int W  = 36;
  localparam int WP = 2;
  localparam int RD = 2;
  localparam int P  = 2 + WP;

  logic           clk = 1'b0;
  logic           reset;
  logic           req;
  logic           we;
  logic [6:0]     addr;
  logic [W-1:0]   wdata;
  logic           busy;
  logic           ack;
  logic [W-1:0]   rdata;
  logic           clear_done;
  logic [6:0]     ram_a;
  logic [W-1:0]   ram_d;
  logic           ram_nen;
  logic           ram_nwrite;
  logic [W-1:0]   ram_q;

  int total = 0;
  int bad   = 0;

  ecl_ram_ctl #(
    .WIDTH(W), .WP_CYCLES(WP), .RD_CYCLES(RD), .CLEAR_ON_RESET(1'b1)
  ) dut (
    .clk(clk), .reset(reset), .req(req), .we(we), .addr(addr), .wdata(wdata),
    .busy(busy), .ack(ack), .rdata(rdata), .clear_done(clear_done),
    .ram_a(ram_a), .ram_d(ram_d), .ram_nen(ram_nen), .ram_nwrite(ram_nwrite),
    .ram_q(ram_q)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h at t=%0t", name, act, exp, $time);
    end
  endtask

  // RAM bank: combinational read, level-sensitive write; filled with non-zero junk at start.
  logic [W-1:0] ram_mem [128];
  bit ram_filled = 1'b0;
  always @(posedge clk) begin
    if (!ram_filled) begin
      for (int i = 0; i < 128; i++) ram_mem[i] <= W'(64'hDEAD_0000_0 + 64'(i) * 64'h1_0101);
      ram_filled <= 1'b1;
    end else if (ram_nen == 1'b0 && ram_nwrite == 1'b0) begin
      ram_mem[ram_a] <= ram_d;
    end
  end
  assign ram_q = ram_nen ? '0 : ram_mem[ram_a];

  // Reference model: tracks sweep position or access phase for the upcoming cycle.
  bit           model_valid = 1'b0;
  bit           clearing    = 1'b0;
  int           sweep_c     = 0;
  bit           acc_on      = 1'b0;
  int           acc_k       = 0;
  bit           acc_we      = 1'b0;
  logic [6:0]   acc_a       = '0;
  logic [W-1:0] acc_d       = '0;
  logic [6:0]   last_a      = '0;
  logic [W-1:0] last_d      = '0;
  logic [W-1:0] m_rdata     = '0;
  bit           m_done      = 1'b0;
  int           epoch       = 0;
  logic [W-1:0] mm [128];

  function automatic int alen(input bit w);
    return w ? WP : RD;
  endfunction

  always @(posedge clk) begin
    if (reset === 1'b1) begin
      model_valid = 1'b1;
      clearing    = 1'b1;
      sweep_c     = 0;
      acc_on      = 1'b0;
      m_rdata     = '0;
      m_done      = 1'b0;
      last_a      = '0;
      last_d      = '0;
      epoch++;
    end else if (model_valid) begin
      if (clearing) begin
        sweep_c++;
        if (sweep_c == 128 * P) begin
          clearing = 1'b0;
          m_done   = 1'b1;
          last_a   = 7'd127;
          last_d   = '0;
          for (int i = 0; i < 128; i++) mm[i] = '0;
        end
      end else if (acc_on) begin
        acc_k++;
        if (acc_k > 2 + alen(acc_we)) begin
          acc_on = 1'b0;
          if (acc_we) mm[acc_a] = acc_d;
        end else if (acc_k == 2 + alen(acc_we) && !acc_we) begin
          m_rdata = mm[acc_a];
        end
      end else if (req === 1'b1) begin
        acc_on = 1'b1;
        acc_k  = 1;
        acc_we = we;
        acc_a  = addr;
        acc_d  = wdata;
        last_a = addr;
        last_d = wdata;
      end
    end
  end

  // Per-cycle compare against the model, plus bus-protocol and sweep-order monitors.
  logic         e_busy, e_ack, e_nen, e_nw;
  logic [6:0]   e_a;
  logic [W-1:0] e_d;
  logic [6:0]   prev_a;
  logic [W-1:0] prev_d;
  logic         prev_nw   = 1'b1;
  logic         prev_done = 1'b0;
  int           pulses    = 0;
  int           mon_epoch = 0;

  always @(negedge clk) begin
    if (model_valid) begin
      if (clearing) begin
        e_busy = 1'b1;
        e_a    = 7'(sweep_c / P);
        e_d    = '0;
        e_nen  = !((sweep_c % P) >= 1 && (sweep_c % P) <= WP);
        e_nw   = e_nen;
        e_ack  = 1'b0;
      end else if (acc_on) begin
        e_busy = 1'b1;
        e_a    = acc_a;
        e_d    = acc_d;
        e_nen  = !(acc_k >= 2 && acc_k < 2 + alen(acc_we));
        e_nw   = acc_we ? e_nen : 1'b1;
        e_ack  = (acc_k == 2 + alen(acc_we));
      end else begin
        e_busy = 1'b0;
        e_a    = last_a;
        e_d    = last_d;
        e_nen  = 1'b1;
        e_nw   = 1'b1;
        e_ack  = 1'b0;
      end
      chk("m_busy",       64'(busy),       64'(e_busy));
      chk("m_ack",        64'(ack),        64'(e_ack));
      chk("m_ram_nen",    64'(ram_nen),    64'(e_nen));
      chk("m_ram_nwrite", 64'(ram_nwrite), 64'(e_nw));
      chk("m_ram_a",      64'(ram_a),      64'(e_a));
      chk("m_ram_d",      64'(ram_d),      64'(e_d));
      chk("m_rdata",      64'(rdata),      64'(m_rdata));
      chk("m_clear_done", 64'(clear_done), 64'(m_done));

      if (ram_nwrite === 1'b0) begin
        chk("nwrite_without_nen", 64'(ram_nen), 64'(0));
        if (prev_nw === 1'b0) begin
          chk("ram_a_moved_in_pulse", 64'(ram_a), 64'(prev_a));
          chk("ram_d_moved_in_pulse", 64'(ram_d), 64'(prev_d));
        end
      end

      if (mon_epoch != epoch) begin
        mon_epoch = epoch;
        pulses    = 0;
      end
      if (clear_done === 1'b0 && prev_nw === 1'b1 && ram_nwrite === 1'b0) begin
        chk("sweep_addr", 64'(ram_a), 64'(pulses));
        chk("sweep_data", 64'(ram_d), 64'(0));
        pulses++;
      end
      if (prev_done === 1'b0 && clear_done === 1'b1) chk("sweep_pulses", 64'(pulses), 64'(128));

      prev_a    = ram_a;
      prev_d    = ram_d;
      prev_nw   = ram_nwrite;
      prev_done = clear_done;
    end
  end

  // Called at a falling edge; returns at the falling edge of an idle cycle.
  task automatic wait_idle();
    int n = 0;
    while (busy !== 1'b0 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (busy !== 1'b0) chk("wait_idle_timeout", 64'(busy), 64'(0));
  endtask

  // One access accepted in the current cycle T; checks timing at T+k by hand.
  task automatic do_access(input bit w, input logic [6:0] a, input logic [W-1:0] d,
                           input bit chk_rd, input logic [W-1:0] exp_rd);
    int len;
    len = w ? WP : RD;
    wait_idle();
    req = 1'b1; we = w; addr = a; wdata = d;
    for (int k = 1; k <= len + 3; k++) begin
      @(negedge clk);
      if (k == 1) begin
        req = 1'b0;
        chk("setup_nen",  64'(ram_nen), 64'(1));
        chk("setup_busy", 64'(busy),    64'(1));
        chk("setup_a",    64'(ram_a),   64'(a));
      end
      if (k == 2) begin
        chk("pulse_nen",    64'(ram_nen),    64'(0));
        chk("pulse_nwrite", 64'(ram_nwrite), 64'(!w));
      end
      if (k == len + 1) chk("last_pulse_nen", 64'(ram_nen), 64'(0));
      if (k == len + 2) begin
        chk("ack",        64'(ack),        64'(1));
        chk("ack_nen",    64'(ram_nen),    64'(1));
        chk("ack_nwrite", 64'(ram_nwrite), 64'(1));
        chk("ack_a",      64'(ram_a),      64'(a));
        if (w) chk("ack_d", 64'(ram_d), 64'(d));
        if (chk_rd) chk("rdata", 64'(rdata), 64'(exp_rd));
      end
      if (k == len + 3) begin
        chk("after_ack",  64'(ack),  64'(0));
        chk("after_busy", 64'(busy), 64'(0));
      end
    end
  endtask

  initial begin
    int i;
    int acks;
    int ack_at [3];
    reset = 1'b1; req = 1'b0; we = 1'b0; addr = '0; wdata = '0;
    repeat (3) @(negedge clk);
    chk("rst_busy",   64'(busy),       64'(1));
    chk("rst_nen",    64'(ram_nen),    64'(1));
    chk("rst_nwrite", 64'(ram_nwrite), 64'(1));
    chk("rst_rdata",  64'(rdata),      64'(0));
    reset = 1'b0;

    // Sweep length: 128 * (2 + WP) = 512 cycles after reset release.
    i = 0;
    while (i < 600 && clear_done !== 1'b1) begin
      @(negedge clk);
      i++;
    end
    chk("clear_time", 64'(i), 64'(512));

    do_access(1'b1, 7'h05, 36'h123456789, 1'b0, '0);
    do_access(1'b0, 7'h05, '0, 1'b1, 36'h123456789);
    do_access(1'b0, 7'h06, '0, 1'b1, 36'h0);

    // req held high across three accesses: acks at T+4, T+9, T+14.
    wait_idle();
    acks = 0;
    req = 1'b1; we = 1'b1; addr = 7'h10; wdata = 36'hA5A5A5A5A;
    for (int k = 1; k <= 17; k++) begin
      @(negedge clk);
      if (k == 1) begin addr = 7'h11; wdata = 36'h0F0F0F0F0; end
      if (k == 6) begin we = 1'b0; addr = 7'h10; wdata = 36'hFFFFFFFFF; end
      if (k == 11) req = 1'b0;
      if (ack === 1'b1) begin
        if (acks < 3) ack_at[acks] = k;
        acks++;
        if (acks == 3) chk("b2b_rdata", 64'(rdata), 64'(36'hA5A5A5A5A));
      end
    end
    chk("b2b_acks", 64'(acks), 64'(3));
    chk("b2b_ack0", 64'(ack_at[0]), 64'(4));
    chk("b2b_ack1", 64'(ack_at[1]), 64'(9));
    chk("b2b_ack2", 64'(ack_at[2]), 64'(14));
    do_access(1'b0, 7'h11, '0, 1'b1, 36'h0F0F0F0F0);

    // Reset in the first W_PULSE cycle, then req pokes during the restarted sweep.
    wait_idle();
    req = 1'b1; we = 1'b1; addr = 7'h22; wdata = 36'h777777777;
    @(negedge clk);
    req = 1'b0;
    @(negedge clk);
    chk("abort_in_pulse", 64'(ram_nwrite), 64'(0));
    reset = 1'b1;
    @(negedge clk);
    chk("abort_nwrite", 64'(ram_nwrite), 64'(1));
    chk("abort_nen",    64'(ram_nen),    64'(1));
    chk("abort_ack",    64'(ack),        64'(0));
    chk("abort_a",      64'(ram_a),      64'(0));
    chk("abort_done",   64'(clear_done), 64'(0));
    reset = 1'b0;
    i = 0;
    acks = 0;
    while (i < 600 && clear_done !== 1'b1) begin
      @(negedge clk);
      i++;
      if (ack === 1'b1) acks++;
      req = ((i % 37) == 5);
      we = i[0];
      addr = 7'(i);
      wdata = W'(i);
    end
    req = 1'b0;
    chk("reclear_time", 64'(i), 64'(512));
    chk("reclear_acks", 64'(acks), 64'(0));
    do_access(1'b0, 7'h22, '0, 1'b1, 36'h0);
    do_access(1'b0, 7'h05, '0, 1'b1, 36'h0);

    repeat (3) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
